// File: rtl/slot_rng_system.sv
// Three-reel slot symbol generator: one 8-bit Fibonacci LFSR per reel, advanced
// while the spin button is held; the low three bits become the registered symbols.
module slot_rng_system #(
    parameter logic [7:0] SEED1 = 8'hA5,
    parameter logic [7:0] SEED2 = 8'h3C,
    parameter logic [7:0] SEED3 = 8'h5E
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_press,
    output logic [2:0] rng1,
    output logic [2:0] rng2,
    output logic [2:0] rng3
);

    // x^8+x^6+x^5+x^4+1; the all-zero state would lock up, so it escapes to 8'h01.
    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        logic [7:0] result;
        if (state == 8'h00) begin
            result = 8'h01;
        end else begin
            result = {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
        end
        return result;
    endfunction

    logic [7:0] lfsr1, lfsr2, lfsr3;
    logic [7:0] next1, next2, next3;

    always_comb begin
        next1 = lfsr_next(lfsr1);
        next2 = lfsr_next(lfsr2);
        next3 = lfsr_next(lfsr3);
    end

    // NOTE: state uses non-blocking assignments so every reel samples the
    // pre-edge LFSR values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr1 <= SEED1;
            lfsr2 <= SEED2;
            lfsr3 <= SEED3;
            rng1  <= 3'b000;
            rng2  <= 3'b000;
            rng3  <= 3'b000;
        end else if (button_press) begin
            lfsr1 <= next1;
            lfsr2 <= next2;
            lfsr3 <= next3;
            rng1  <= next1[2:0];
            rng2  <= next2[2:0];
            rng3  <= next3[2:0];
        end
    end

endmodule

// File: tb/tb_slot_rng_system.sv
// Self-checking bench for slot_rng_system: symbols are predicted from a table of
// each reel's full 255-state sequence, indexed by the number of enabled edges.
module tb_slot_rng_system;

    logic       clk;
    logic       reset;
    logic       button_press;
    logic [2:0] rng1, rng2, rng3;
    logic [2:0] z_rng1, z_rng2, z_rng3;

    int compared   = 0;
    int mismatched = 0;

    slot_rng_system dut (
        .clk         (clk),
        .reset       (reset),
        .button_press(button_press),
        .rng1        (rng1),
        .rng2        (rng2),
        .rng3        (rng3)
    );

    // Zero-seed build on reel 1 exercises the lock-up escape.
    slot_rng_system #(.SEED1(8'h00)) dut_z (
        .clk         (clk),
        .reset       (reset),
        .button_press(button_press),
        .rng1        (z_rng1),
        .rng2        (z_rng2),
        .rng3        (z_rng3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full sequence per reel plus a count of enabled edges.
    logic [7:0] seq [3][255];
    int         presses;
    bit         started;

    function automatic logic [2:0] exp_sym(input int reel);
        logic [2:0] r;
        r = started ? seq[reel][presses % 255][2:0] : 3'd0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reels(input string tag);
        check({tag, "_rng1"}, {5'd0, rng1}, {5'd0, exp_sym(0)});
        check({tag, "_rng2"}, {5'd0, rng2}, {5'd0, exp_sym(1)});
        check({tag, "_rng3"}, {5'd0, rng3}, {5'd0, exp_sym(2)});
    endtask

    // One clock: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic bp, input string tag);
        @(negedge clk);
        button_press = bp;
        @(posedge clk);
        #1;
        if (bp) begin
            presses++;
            started = 1'b1;
        end
        check_reels(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        button_press = 1'b0;
        presses      = 0;
        started      = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] seeds [3];
        logic [7:0] s;
        seeds[0] = 8'hA5;
        seeds[1] = 8'h3C;
        seeds[2] = 8'h5E;
        for (int r = 0; r < 3; r++) begin
            s = seeds[r];
            for (int i = 0; i < 255; i++) begin
                seq[r][i] = s;
                s = {s[6:0], ^(s & 8'hB8)};
            end
        end

        presses      = 0;
        started      = 1'b0;
        button_press = 1'b0;
        reset        = 1'b0;
        #12;
        check_reels("reset");
        check("reset_lfsr1", dut.lfsr1, 8'hA5);
        check("reset_lfsr2", dut.lfsr2, 8'h3C);
        check("reset_lfsr3", dut.lfsr3, 8'h5E);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, "idle_after_reset");

        step(1'b1, "press1");
        check("press1_rng1_const", {5'd0, rng1}, 8'd2);
        check("press1_rng2_const", {5'd0, rng2}, 8'd1);
        check("press1_rng3_const", {5'd0, rng3}, 8'd4);
        check("press1_lfsr1", dut.lfsr1, 8'h4A);
        check("press1_lfsr2", dut.lfsr2, 8'h79);
        check("press1_lfsr3", dut.lfsr3, 8'hBC);
        step(1'b1, "press2");
        check("press2_lfsr1", dut.lfsr1, 8'h95);
        check("press2_rng1_const", {5'd0, rng1}, 8'd5);

        for (int i = 0; i < 100; i++) step(1'b0, "hold");
        for (int i = 0; i < 3; i++) step(1'b1, "resume");

        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), "random");

        // Glitch between edges must be ignored.
        @(negedge clk);
        button_press = 1'b0;
        #1 button_press = 1'b1;
        #1 button_press = 1'b0;
        @(posedge clk);
        #1;
        check_reels("glitch");

        // Full period from the seeds.
        do_reset();
        for (int i = 0; i < 510; i++) begin
            step(1'b1, "period");
            if (presses == 255) begin
                check("period_lfsr1", dut.lfsr1, 8'hA5);
                check("period_lfsr2", dut.lfsr2, 8'h3C);
                check("period_lfsr3", dut.lfsr3, 8'h5E);
            end
        end

        // Asynchronous reset between edges while spinning.
        step(1'b1, "prespin");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        presses = 0;
        started = 1'b0;
        check_reels("async_reset");
        check("async_reset_lfsr1", dut.lfsr1, 8'hA5);
        @(negedge clk);
        reset        = 1'b1;
        button_press = 1'b0;

        step(1'b1, "after_reset_press1");
        check("lockup_rng1_p1", {5'd0, z_rng1}, 8'd1);
        check("lockup_lfsr1_p1", dut_z.lfsr1, 8'h01);
        step(1'b1, "after_reset_press2");
        check("lockup_rng1_p2", {5'd0, z_rng1}, 8'd2);
        check("lockup_rng2_p2", {5'd0, z_rng2}, {5'd0, seq[1][2][2:0]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/slot_rng_system.md
Name: slot_rng_system

Overview:
Three-reel random symbol generator for the casino slot machine. While the player holds the spin button, three independent 8-bit LFSRs advance every clock. Each reel's 3-bit symbol (0-7) is taken from its LFSR. When the button is released the symbols freeze, and the frozen values feed the downstream payout/display logic. Behavioural and gate-level implementations of this block must be cycle-for-cycle identical at the ports.

Parameters:
SEED1, 8'hA5, reset/reload value of reel-1 LFSR (must be nonzero)
SEED2, 8'h3C, reset/reload value of reel-2 LFSR (must be nonzero)
SEED3, 8'h5E, reset/reload value of reel-3 LFSR (must be nonzero)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
button_press  input  1  spin enable; level-sensitive, 1 = reels spinning
rng1  output  3  reel-1 symbol, registered
rng2  output  3  reel-2 symbol, registered
rng3  output  3  reel-3 symbol, registered

Behaviour:
- Reset (reset=0, asynchronous, dominates everything):
  - lfsr1/2/3 <= SEED1/2/3.
  - rng1/2/3 <= 3'b000.
  - Release is synchronised by the first clock edge with reset=1. No update happens on the edge where reset deasserts.
- LFSR, identical for all three reels:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, maximal period 255.
  - fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
  - next = {lfsr[6:0], fb}.
- Lock-up guard: if an LFSR value is 8'h00 (e.g. a zero seed or an upset), its next value is 8'h01 instead of the shift result.
- Rising clk edge with button_press=1, for each reel N:
  - lfsrN <= nextN.
  - rngN <= nextN[2:0].
  - Latency is one clock: a symbol is visible right after the edge that advanced its LFSR.
- Rising clk edge with button_press=0: all LFSRs and outputs hold.
  - The last symbols stay stable indefinitely; this is the "stop" result.
  - A new press resumes each sequence from where it stopped; no reseed.
- Reel independence:
  - The three reels update on the same edges but never share state.
  - Distinct seeds keep the reels at fixed sequence offsets from one another.
- button_press is sampled only at clock edges; glitches between edges have no effect. It is assumed synchronous to clk; the block has no synchroniser.
- Reset mid-spin: immediate return to seeds and zero outputs, regardless of button_press. Spinning restarts from the seeds once reset=1.
- Outputs are driven only from flops, never combinationally from button_press.
- All symbol values 0..7 are legal. There is no reserved code; jackpot detection (all three equal) is the downstream logic's job.

Test Plan:
- Reset: reset=0 with default seeds -> rng1/2/3 = 0/0/0, internal LFSRs = A5/3C/5E. Outputs stay 0 while button_press=0 after reset release.
- One press cycle: button_press=1 for exactly one clock after reset -> LFSRs = 4A/79/BC, so rng1=2, rng2=1, rng3=4.
- Two press cycles on reel 1: second enabled edge -> lfsr1=95, rng1=5.
- Hold: after any press sequence, button_press=0 for 100 cycles -> rng1/2/3 unchanged every cycle.
  - Re-asserting the button continues the sequence; it does not restart from the seed.
- Period: hold button_press=1 for 255 edges from reset -> each LFSR returns to its seed. The rng sequences of edges 256..510 equal those of edges 1..255.
- Async reset mid-spin and lock-up: assert reset=0 between clock edges while spinning -> outputs go to 0 immediately with no clock edge.
  - Then force lfsr1=00 (SEED1=0 build) and press once -> lfsr1=01, rng1=1.
